// File: rtl/comparator_serial_nbit.sv
// Bit-serial magnitude comparator: captures A/B on start, walks MSB-first one bit per
// clock and stops at the first differing bit. Unsigned or two's-complement per request.
module comparator_serial_nbit #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_m,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic             GT,
   output logic             EQ,
   output logic             LT,
   output logic [CW-1:0]    bits_used
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             gt_q, gt_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;
   logic [CW-1:0]    bits_q, bits_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic [2:0]       verdict_s;

   // Operands shift left each step, so the bit under test is always the MSB.
   // In signed mode the first examined bit is the sign bit and its sense is inverted.
   function automatic logic [2:0] bit_verdict(input logic a_bit, input logic invert);
      return (a_bit ^ invert) ? 3'b100 : 3'b001;
   endfunction

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      idx_d     = idx_q;
      gt_d      = gt_q;
      eq_d      = eq_q;
      lt_d      = lt_q;
      bits_d    = bits_q;
      done_d    = 1'b0;
      ready_d   = 1'b0;
      verdict_s = bit_verdict(a_q[WIDTH-1], sgn_q && (idx_q == CW'(WIDTH - 1)));
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               sgn_d   = signed_m;
               idx_d   = CW'(WIDTH - 1);
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               bits_d  = {CW{1'b0}};
               state_d = ST_BUSY;
            end else begin
               ready_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (a_q[WIDTH-1] != b_q[WIDTH-1]) begin
               gt_d    = verdict_s[2];
               lt_d    = verdict_s[0];
               bits_d  = CW'(WIDTH) - idx_q;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (idx_q == {CW{1'b0}}) begin
               eq_d    = 1'b1;
               bits_d  = CW'(WIDTH);
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q - CW'(1);
               a_d   = a_q << 1'b1;
               b_d   = b_q << 1'b1;
            end
         end
         ST_DONE: begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand and output registers; reset aborts any compare in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sgn_q   <= 1'b0;
         idx_q   <= {CW{1'b0}};
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         bits_q  <= {CW{1'b0}};
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         idx_q   <= idx_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         bits_q  <= bits_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign GT        = gt_q;
   assign EQ        = eq_q;
   assign LT        = lt_q;
   assign bits_used = bits_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Scoreboard bench for comparator_serial_nbit: three instances (WIDTH 8, 4, 1), expected
// results from an arithmetic reference model, checked by per-cycle monitors.
module tb_comparator_serial_nbit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       st8 = 1'b0, s8 = 1'b0, rdy8, dn8, gt8, eq8, lt8;
   logic [7:0] a8 = 8'd0, b8 = 8'd0;
   logic [3:0] bu8;
   logic       st4 = 1'b0, s4 = 1'b0, rdy4, dn4, gt4, eq4, lt4;
   logic [3:0] a4 = 4'd0, b4 = 4'd0;
   logic [2:0] bu4;
   logic       st1 = 1'b0, s1 = 1'b0, rdy1, dn1, gt1, eq1, lt1;
   logic [0:0] a1 = 1'b0, b1 = 1'b0;
   logic [0:0] bu1;

   typedef struct {
      int res;
      int bits;
      int cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   comparator_serial_nbit #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .signed_m(s8), .A(a8), .B(b8),
      .ready(rdy8), .done(dn8), .GT(gt8), .EQ(eq8), .LT(lt8), .bits_used(bu8));
   comparator_serial_nbit #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .signed_m(s4), .A(a4), .B(b4),
      .ready(rdy4), .done(dn4), .GT(gt4), .EQ(eq4), .LT(lt4), .bits_used(bu4));
   comparator_serial_nbit #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .signed_m(s1), .A(a1), .B(b1),
      .ready(rdy1), .done(dn1), .GT(gt1), .EQ(eq1), .LT(lt1), .bits_used(bu1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference: integer compare after optional sign extension; bits = distance from MSB
   // to the highest differing bit, inclusive.
   function automatic exp_t model(int a, int b, bit s, int w);
      exp_t e;
      int sa = a, sb = b, d, m;
      if (s && ((a >> (w - 1)) & 1) == 1) sa = a - (1 << w);
      if (s && ((b >> (w - 1)) & 1) == 1) sb = b - (1 << w);
      e.res = (sa > sb) ? 4 : ((sa == sb) ? 2 : 1);
      d = a ^ b;
      if (d == 0) e.bits = w;
      else begin
         m = w - 1;
         while (((d >> m) & 1) == 0) m--;
         e.bits = w - m;
      end
      e.cyc = 0;
      return e;
   endfunction

   task automatic issue(int w, int a, int b, bit s);
      exp_t e;
      bit   ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         case (w)
            8: ok = rdy8;
            4: ok = rdy4;
            default: ok = rdy1;
         endcase
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout width %0d @cycle %0d: got ready=0 expected ready=1", w, cyc);
         return;
      end
      e = model(a, b, s, w);
      e.cyc = cyc + e.bits + 1;
      case (w)
         8: begin a8 = 8'(a); b8 = 8'(b); s8 = s; st8 = 1'b1; q8.push_back(e); end
         4: begin a4 = 4'(a); b4 = 4'(b); s4 = s; st4 = 1'b1; q4.push_back(e); end
         default: begin a1 = 1'(a); b1 = 1'(b); s1 = s; st1 = 1'b1; q1.push_back(e); end
      endcase
      @(posedge clk); #1;
      st8 = 1'b0; st4 = 1'b0; st1 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
   endtask

   task automatic mon(int w, logic rdy, logic dn, logic [2:0] res, logic [3:0] bu);
      exp_t e;
      bit   have = 1'b0;
      if (dn) begin
         case (w)
            8: if (q8.size() != 0) begin e = q8.pop_front(); have = 1'b1; end
            4: if (q4.size() != 0) begin e = q4.pop_front(); have = 1'b1; end
            default: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done width %0d @cycle %0d: got done=1 expected done=0", w, cyc);
         end else begin
            chk($sformatf("result_w%0d", w), 32'(res), e.res);
            chk($sformatf("bits_used_w%0d", w), 32'(bu), e.bits);
            chk($sformatf("latency_w%0d", w), cyc, e.cyc);
            chk($sformatf("ready_in_done_w%0d", w), 32'(rdy), 0);
         end
      end else if (!rdy) begin
         chk($sformatf("busy_clear_w%0d", w), {25'd0, res, bu}, 0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(8, rdy8, dn8, {gt8, eq8, lt8}, bu8);
         mon(4, rdy4, dn4, {gt4, eq4, lt4}, 4'(bu4));
         mon(1, rdy1, dn1, {gt1, eq1, lt1}, 4'(bu1));
      end
   end

   task automatic drain();
      for (int i = 0; i < 100 && (q8.size() + q4.size() + q1.size()) != 0; i++)
         @(posedge clk);
      repeat (2) @(posedge clk);
      if ((q8.size() + q4.size() + q1.size()) != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q8.size() + q4.size() + q1.size());
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_ready", 32'(rdy8), 1);
      chk("rst_done", 32'(dn8), 0);
      chk("rst_flags", {29'd0, gt8, eq8, lt8}, 0);
      chk("rst_bits_used", 32'(bu8), 0);
   endtask

   initial begin
      #12;
      chk_reset_state();
      chk("rst_ready_w4", 32'(rdy4), 1);
      chk("rst_ready_w1", 32'(rdy1), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(8, 8'h5A, 8'h5A, 1'b0);
      st8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      @(posedge clk); #1;
      st8 = 1'b0;
      issue(8, 8'h80, 8'h7F, 1'b0);
      issue(8, 8'h80, 8'h7F, 1'b1);
      issue(8, 8'h12, 8'h13, 1'b0);
      issue(8, 8'h7F, 8'hFE, 1'b1);
      issue(8, 8'hC3, 8'hC3, 1'b1);
      drain();

      issue(8, 8'h5A, 8'h5A, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_state();
      q8.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(8, 8'h01, 8'h00, 1'b0);
      drain();

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int s = 0; s < 2; s++)
               issue(4, a, b, 1'(s));
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++)
            for (int s = 0; s < 2; s++)
               issue(1, a, b, 1'(s));
      drain();

      for (int i = 0; i < 150; i++) begin
         int ra, rb;
         ra = int'($urandom_range(0, 255));
         rb = ($urandom_range(0, 3) == 0) ? (ra ^ (1 << $urandom_range(0, 7)))
                                          : int'($urandom_range(0, 255));
         issue(8, ra, rb, 1'($urandom));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
